// File: rtl/poly_zq_to_r3.sv
// poly_zq_to_r3
//   Streams the P coefficients of a Zq polynomial out of a synchronous source
//   RAM, centred-lifts each one to [-q/2, q/2-1], reduces it mod 3 and writes
//   the 2-bit R3 coefficient (0 -> 0, 1 -> +1, 2 -> -1) into a destination
//   RAM. Nonzero outputs are counted; the final Hamming weight and a
//   weight == 2*T flag are handed to the downstream weight-check stage.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a conversion (only looked at in IDLE)
//   rd_en/rd_addr        source RAM read port (registered)
//   rd_data              source RAM data, valid one cycle after rd_en
//   wr_en/wr_addr/wr_data destination RAM write port (registered)
//   busy                 reads or writes in flight
//   done                 one-cycle completion pulse
//   weight/weight_ok     Hamming weight and weight == 2*T, valid from done
//
// Start semantics: start is a level request, accepted on any rising edge
// where the block is IDLE; a request seen in RUN, DRAIN or DONE is dropped.
module poly_zq_to_r3 #(
    parameter int P      = 677,
    parameter int Q_BITS = 11,
    parameter int T      = 101,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [Q_BITS-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   weight,
    output logic              weight_ok
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(P - 1);
    localparam logic [ADDR_W:0]   TARGET    = (ADDR_W + 1)'(2 * T);
    localparam int                NDIG      = (Q_BITS + 1) / 2;
    // q = 2^Q_BITS is 2 mod 3 for odd Q_BITS and 1 mod 3 for even Q_BITS.
    // Subtracting q mod 3 equals adding (3 - q mod 3).
    localparam logic [1:0]        LIFT_ADJ  = (Q_BITS % 2 == 1) ? 2'd1 : 2'd2;

    state_t              state;
    logic                drain_cnt;
    logic                p1_valid;
    logic [ADDR_W-1:0]   p1_addr;
    logic [1:0]          r3;
    logic [ADDR_W:0]     weight_nxt;

    // Unsigned residue mod 3: 4^k == 1 (mod 3), so the residue of a number
    // equals the residue of the sum of its base-4 digits. Fold twice, then a
    // small table finishes the job.
    function automatic logic [1:0] mod3_u(input logic [Q_BITS-1:0] c);
        logic [2*NDIG-1:0] cp;
        logic [7:0]        s1;
        logic [3:0]        s2;
        logic [2:0]        s3;
        logic [1:0]        m;
        cp = (2*NDIG)'(c);
        s1 = 8'd0;
        for (int i = 0; i < NDIG; i++) begin
            s1 = s1 + 8'(cp[2*i +: 2]);
        end
        s2 = 4'(s1[1:0]) + 4'(s1[3:2]) + 4'(s1[5:4]) + 4'(s1[7:6]);
        s3 = 3'(s2[1:0]) + 3'(s2[3:2]);
        case (s3)
            3'd0, 3'd3, 3'd6: m = 2'd0;
            3'd1, 3'd4, 3'd7: m = 2'd1;
            default:          m = 2'd2;
        endcase
        return m;
    endfunction

    // Centred lift: coefficients with the top bit set represent c - q.
    always_comb begin
        logic [1:0] m;
        logic [2:0] t;
        m = mod3_u(rd_data);
        t = {1'b0, m};
        if (rd_data[Q_BITS-1]) begin
            t = t + {1'b0, LIFT_ADJ};
        end
        r3 = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    end

    // Weight including the write being registered this cycle, so the flag
    // captured on entry to DONE always sees the final count.
    assign weight_nxt = weight + {{ADDR_W{1'b0}}, (p1_valid && (r3 != 2'd0))};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
            p1_valid  <= 1'b0;
            p1_addr   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            weight    <= '0;
            weight_ok <= 1'b0;
        end else begin
            // Stage 1: address delayed to line up with the RAM output.
            p1_valid <= rd_en;
            p1_addr  <= rd_addr;
            // Stage 2: reduced coefficient goes straight to the write port.
            wr_en <= p1_valid;
            if (p1_valid) begin
                wr_addr <= p1_addr;
                wr_data <= r3;
            end

            if (state == S_IDLE && start) begin
                weight <= '0;
            end else begin
                weight <= weight_nxt;
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_RUN;
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                        busy      <= 1'b1;
                        weight_ok <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (rd_addr == LAST_ADDR) begin
                        rd_en     <= 1'b0;
                        drain_cnt <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        weight_ok <= (weight_nxt == TARGET);
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_zq_to_r3.sv
// Bench for poly_zq_to_r3: source RAM model, write monitor, directed scenarios.
module tb_poly_zq_to_r3;

    localparam int P      = 677;
    localparam int Q_BITS = 11;
    localparam int T      = 101;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [Q_BITS-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   weight;
    logic              weight_ok;

    int tests = 0;
    int fails = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    poly_zq_to_r3 #(.P(P), .Q_BITS(Q_BITS), .T(T), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .weight(weight), .weight_ok(weight_ok)
    );

    // ---------------- source RAM model ----------------
    logic [Q_BITS-1:0] src_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

    // Reference: centred lift then mod 3 in plain integer arithmetic.
    function automatic logic [1:0] ref_r3(input logic [Q_BITS-1:0] c);
        int v;
        v = (int'(c) < 1024) ? int'(c) : int'(c) - 2048;
        return 2'(((v % 3) + 3) % 3);
    endfunction

    // ---------------- monitor ----------------
    bit   mon_on = 0;
    int   t0 = 0;
    int   rel;
    int   done_cnt, done_cyc, wr_cnt, data_err, time_err, busy_err, rd_err;
    int   wr_hits [0:P-1];
    logic [1:0] wr_log [0:P-1];

    always @(negedge clk) begin
        if (mon_on) begin
            rel = cyc - t0 + 1;
            if (rd_en) begin
                if (!(rel >= 1 && rel <= P && int'(rd_addr) == rel - 1)) rd_err++;
            end else if (rel >= 1 && rel <= P) begin
                rd_err++;
            end
            if (busy !== (rel >= 1 && rel <= P + 2)) busy_err++;
            if (wr_en) begin
                wr_cnt++;
                if (int'(wr_addr) < P) begin
                    wr_hits[wr_addr]++;
                    wr_log[wr_addr] = wr_data;
                    if (wr_data !== ref_r3(src_mem[wr_addr])) data_err++;
                    if (rel != int'(wr_addr) + 3) time_err++;
                end else begin
                    data_err++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = rel;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < (1 << ADDR_W); i++) src_mem[i] = '0;
    endtask

    // Pulses start, follows one full conversion through the monitor and
    // checks everything the run should have produced.
    task automatic run_and_check(input string name, input int exp_w, input bit exp_ok);
        int n;
        int miss;
        done_cnt = 0; done_cyc = -1; wr_cnt = 0; data_err = 0;
        time_err = 0; busy_err = 0; rd_err = 0;
        for (int i = 0; i < P; i++) wr_hits[i] = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        mon_on = 1;
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #1 mon_on = 0;
        miss = 0;
        for (int i = 0; i < P; i++) if (wr_hits[i] != 1) miss++;
        tests++; if (n >= 2000) begin fails++; $display("FAIL %s timeout: no done within %0d cycles", name, n); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL %s done_count got %0d want 1", name, done_cnt); end
        tests++; if (done_cyc !== P + 3) begin fails++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, P + 3); end
        tests++; if (wr_cnt !== P) begin fails++; $display("FAIL %s write_count got %0d want %0d", name, wr_cnt, P); end
        tests++; if (miss !== 0) begin fails++; $display("FAIL %s addr_coverage got %0d bad addrs want 0", name, miss); end
        tests++; if (data_err !== 0) begin fails++; $display("FAIL %s wr_data errors got %0d want 0", name, data_err); end
        tests++; if (time_err !== 0) begin fails++; $display("FAIL %s write_timing errors got %0d want 0", name, time_err); end
        tests++; if (busy_err !== 0) begin fails++; $display("FAIL %s busy errors got %0d want 0", name, busy_err); end
        tests++; if (rd_err !== 0) begin fails++; $display("FAIL %s read errors got %0d want 0", name, rd_err); end
        tests++; if (weight !== (ADDR_W+1)'(exp_w)) begin fails++; $display("FAIL %s weight got %0d want %0d", name, weight, exp_w); end
        tests++; if (weight_ok !== exp_ok) begin fails++; $display("FAIL %s weight_ok got %0b want %0b", name, weight_ok, exp_ok); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [37:0] obs;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        obs = {rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, weight, weight_ok};
        tests++; if (obs !== '0) begin fails++; $display("FAIL reset_outputs got %h want 0", obs); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if ({busy, rd_en, done} !== 3'b000) begin fails++; $display("FAIL idle_after_reset got %b want 000", {busy, rd_en, done}); end
    endtask

    task automatic test_all_zero();
        clear_mem();
        run_and_check("all_zero", 0, 1'b0);
    endtask

    task automatic test_pattern();
        logic [1:0] exp_d [0:7];
        clear_mem();
        src_mem[0] = 11'd1;    src_mem[1] = 11'd2047; src_mem[2] = 11'd1024;
        src_mem[3] = 11'd1023; src_mem[4] = 11'd3;    src_mem[5] = 11'd5;
        src_mem[6] = 11'd2;    src_mem[7] = 11'd1022;
        exp_d[0] = 2'd1; exp_d[1] = 2'd2; exp_d[2] = 2'd2; exp_d[3] = 2'd0;
        exp_d[4] = 2'd0; exp_d[5] = 2'd2; exp_d[6] = 2'd2; exp_d[7] = 2'd2;
        run_and_check("pattern", 6, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (wr_log[i] !== exp_d[i]) begin
                fails++; $display("FAIL pattern_addr%0d wr_data got %0d want %0d", i, wr_log[i], exp_d[i]);
            end
        end
    endtask

    task automatic load_ones(input int count);
        clear_mem();
        // 677 is prime, so i*337 mod 677 hits distinct, scattered addresses.
        for (int i = 0; i < count; i++) src_mem[(i * 337) % P] = 11'd1;
    endtask

    task automatic test_weight_boundary();
        load_ones(2 * T);
        run_and_check("weight_202", 2 * T, 1'b1);
        load_ones(2 * T + 1);
        run_and_check("weight_203", 2 * T + 1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [37:0] obs;
        int dn;
        int bz;
        load_ones(2 * T);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int r = 1; r <= 300; r++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 obs = {rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, weight, weight_ok};
        tests++; if (obs !== '0) begin fails++; $display("FAIL reset_mid_run outputs got %h want 0", obs); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dn = 0; bz = 0;
        for (int r = 0; r < 800; r++) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bz++;
        end
        tests++; if (dn !== 0) begin fails++; $display("FAIL reset_mid_run done pulses got %0d want 0", dn); end
        tests++; if (bz !== 0) begin fails++; $display("FAIL reset_mid_run busy cycles got %0d want 0", bz); end
        run_and_check("after_reset", 2 * T, 1'b1);
    endtask

    task automatic test_start_handling();
        int dn;
        int d_first;
        int d_second;
        clear_mem();
        src_mem[0] = 11'd1;    src_mem[1] = 11'd2047; src_mem[2] = 11'd1024;
        src_mem[5] = 11'd5;    src_mem[6] = 11'd2;    src_mem[7] = 11'd1022;
        dn = 0; d_first = -1; d_second = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int r = 1; r <= 1400; r++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (dn == 1) d_first = r; else if (dn == 2) d_second = r;
            end
            if (r == 681) begin
                tests++; if ({busy, rd_en} !== 2'b00) begin fails++; $display("FAIL restart idle_gap busy,rd_en got %b want 00", {busy, rd_en}); end
            end
            if (r == 682) begin
                tests++; if ({rd_en, rd_addr} !== {1'b1, 10'd0}) begin fails++; $display("FAIL restart first_read got %b/%0d want 1/0", rd_en, rd_addr); end
                tests++; if (weight !== '0) begin fails++; $display("FAIL restart weight_cleared got %0d want 0", weight); end
            end
            start = (r == 100 || r == 680 || r == 681);
        end
        start = 1'b0;
        tests++; if (dn !== 2) begin fails++; $display("FAIL start_handling done pulses got %0d want 2", dn); end
        tests++; if (d_first !== 680) begin fails++; $display("FAIL start_handling first done cycle got %0d want 680", d_first); end
        tests++; if (d_second !== 1361) begin fails++; $display("FAIL start_handling second done cycle got %0d want 1361", d_second); end
        tests++; if (weight !== 11'd6) begin fails++; $display("FAIL start_handling weight got %0d want 6", weight); end
    endtask

    task automatic test_sweep();
        int w;
        clear_mem();
        w = 0;
        for (int i = 0; i < P; i++) begin
            src_mem[i] = 11'(i);
            if (ref_r3(11'(i)) != 2'd0) w++;
        end
        run_and_check("sweep_low", w, (w == 2 * T));
        w = 0;
        for (int i = 0; i < P; i++) begin
            src_mem[i] = 11'(1371 + i);
            if (ref_r3(11'(1371 + i)) != 2'd0) w++;
        end
        run_and_check("sweep_high", w, (w == 2 * T));
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_all_zero();
        test_pattern();
        test_weight_boundary();
        test_reset_mid_run();
        test_start_handling();
        repeat (3) @(negedge clk);
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/poly_zq_to_r3.md
Name: poly_zq_to_r3

Overview:
- Upstream stage of the decapsulation lift/weight-check stage.
- Streams the P coefficients of a Zq polynomial out of a synchronous source RAM.
- Centred-lifts each coefficient to the signed range [-Q/2, Q/2-1], reduces it mod 3, and writes the 2-bit R3 coefficient into the destination RAM.
- Counts nonzero R3 coefficients while it runs, and reports the final Hamming weight plus a weight==2*T flag for the downstream stage.

Parameters:
- P, 677, number of polynomial coefficients.
- Q_BITS, 11, coefficient width; q = 2^Q_BITS = 2048.
- T, 101, weight parameter; the target weight is 2*T = 202.
- ADDR_W, 10, RAM address width; 2^ADDR_W >= P.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin conversion; sampled only in IDLE.
- rd_en, output, 1, source RAM read enable.
- rd_addr, output, ADDR_W, source RAM address.
- rd_data, input, Q_BITS, source RAM data; valid one cycle after rd_en.
- wr_en, output, 1, destination RAM write enable.
- wr_addr, output, ADDR_W, destination RAM address.
- wr_data, output, 2, R3 coefficient: 0 -> 0, 1 -> +1, 2 -> -1.
- busy, output, 1, high while reads or writes are in flight.
- done, output, 1, one-cycle pulse when the result is complete.
- weight, output, ADDR_W+1, count of nonzero R3 coefficients.
- weight_ok, output, 1, weight == 2*T; valid from the done pulse.

Behaviour:
- Reset (rst_n=0, asynchronous)
  - State goes to IDLE.
  - rd_en, wr_en, busy, done, weight_ok = 0; rd_addr, wr_addr, wr_data, weight = 0.
  - The pipeline and read counter are cleared.
  - Applies immediately, including mid-conversion. No partial completion is signalled; partial destination contents are don't-care.
- States: IDLE, RUN, DRAIN, DONE. Encoding is free.
- IDLE
  - All strobes low.
  - On start=1: clear weight and weight_ok, load read counter k=0, go to RUN.
- RUN
  - rd_en=1, rd_addr=k, busy=1, k increments every cycle.
  - When k==P-1 is issued, go to DRAIN.
  - Exactly P consecutive cycles, with no bubbles.
- DRAIN
  - rd_en=0, busy=1, lasts 2 cycles to flush the pipeline, then DONE.
- DONE
  - done=1 and busy=0 for one cycle, then IDLE.
  - weight and weight_ok hold their values until the next accepted start.
- Pipeline
  - Stage 1: rd_data is captured together with the delayed address.
  - Stage 2: the registered outputs wr_en, wr_addr, wr_data are driven.
  - Each write appears exactly 2 cycles after its read issue.
- Timing: with start sampled at edge 0,
  - read addr 0 is issued in cycle 1;
  - write addr 0 occurs in cycle 3;
  - the last write, addr P-1, occurs in cycle P+2;
  - done is high in cycle P+3 (cycle 680 for P=677).
- Arithmetic
  - Centred lift: v = c if c < q/2, else c - q; v is 12-bit signed.
  - r = ((v mod 3) + 3) mod 3, giving r in {0,1,2}.
  - Must be exact over the full range -1024..1023. No divider inference; a constant-folding/adder-tree approach is acceptable.
  - weight increments by 1 on each write with r != 0 and cannot overflow, since P < 2^(ADDR_W+1).
  - weight_ok is registered when entering DONE.
- Start handling
  - start while in RUN, DRAIN or DONE is ignored and not queued.
  - start held high continuously restarts a conversion on the cycle after DONE, from IDLE.
- Addresses never exceed P-1; rd_addr and wr_addr hold their last value when idle.

Test Plan:
- Source RAM all zero, pulse start -> 677 writes of 0 at addrs 0..676 in cycles 3..679, done in cycle 680 only, busy high in cycles 1..679, weight=0, weight_ok=0.
- Coefficients 0:1, 1:2047, 2:1024, 3:1023, 4:3, 5:5, 6:2, 7:1022, rest 0 -> wr_data 1,2,2,0,0,2,2,2 for addrs 0..7, weight=6.
- Exactly 202 coefficients = 1 at scattered addresses, rest 0 -> weight=202, weight_ok=1. Repeat with 203 -> weight=203, weight_ok=0.
- rst_n pulsed low at cycle 300 of a run -> all outputs 0 asynchronously, state IDLE, no done pulse. A fresh start then completes normally with the correct weight.
- start re-asserted at cycles 100 and 680 (DONE) -> ignored, single done. start in cycle 681 (IDLE) -> second run begins, weight cleared to 0 at acceptance.
- Exhaustive sweep: memory loaded with values 0..676, then a second pass with 1371..2047 -> every wr_data matches a reference model of centred lift mod 3.
